fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Control FSM that drives the 8-bit fetch unit's control inputs (init, stall, branch, jump, done) from decode-stage information and hazard/memory-wait indications. Sits between the decoder/hazard logic and the fetch unit. Owns start-up, pipeline stalls, post-redirect squash bubbles and halt, and keeps performance counters for stall cycles and redirects.

## Interface
- FLUSH_CYCLES, 1, squash bubbles after a taken branch/jump (0..15; 0 = no squash state)
- STALL_CNT_W, 16, width of stall_count

- clock  in  1  system clock; state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin execution from PC 0 (honoured in IDLE and HALT only)
- dec_valid  in  1  decode stage holds a valid instruction
- dec_is_branch  in  1  decoded instruction is a conditional branch
- branch_cond  in  1  branch condition true (taken)
- dec_is_jump  in  1  decoded instruction is a jump
- dec_is_halt  in  1  decoded instruction is halt
- hazard  in  1  data hazard; hold fetch this cycle
- mem_wait  in  1  data memory not ready; hold fetch this cycle
- init_ctrl  out  1  to fetch unit: reset PC to 0
- branch_ctrl  out  1  to fetch unit: PC += branch value
- jump_ctrl  out  1  to fetch unit: PC = jump value
- stall  out  1  to fetch unit: hold PC
- done_ctrl  out  1  to fetch unit: program finished
- squash  out  1  invalidate instruction in decode
- busy  out  1  state is INIT, RUN or FLUSH
- stall_count  out  STALL_CNT_W  stall cycles in RUN/FLUSH, saturating
- redirect_count  out  8  taken branches + jumps, wraps 255->0

## Operation
- States: IDLE, INIT, RUN, FLUSH, HALT. Reset -> IDLE, flush counter 0, both counters 0.
- Control outputs are Mealy: decoded from registered state and current inputs, stable before the falling edge at which the fetch unit samples them. With reset_n low all outputs are 0 except stall=1.
- IDLE: stall=1, all else 0. start -> INIT.
- INIT: init_ctrl=1, stall=0, for exactly one cycle; -> RUN. Counters cleared on INIT entry.
- RUN, evaluated in priority order:
  - dec_valid=0: no controls asserted; stay RUN.
  - dec_valid & dec_is_halt: done_ctrl=1, stall=1; -> HALT.
  - hazard | mem_wait: stall=1, no redirect issued (instruction re-presented next cycle); stall_count+1.
  - dec_is_branch & branch_cond: branch_ctrl=1, squash=1, redirect_count+1; -> FLUSH with counter=FLUSH_CYCLES (stay RUN if 0).
  - dec_is_jump: jump_ctrl=1, same squash/count/FLUSH behaviour.
  - Branch and jump both asserted: branch wins (matches fetch-unit priority); one redirect counted.
  - Branch not taken: no controls; fetch advances.
- FLUSH: squash=1, stall=0; counter decrements each non-stalled cycle; counter==1 and decrementing -> RUN. Branch/jump/halt ignored (squashed). mem_wait: stall=1, counter holds, stall_count+1. hazard ignored.
- HALT: done_ctrl=1, stall=1, sticky. start -> INIT; otherwise only reset exits.
- start in INIT/RUN/FLUSH ignored.
- stall_count saturates at all-ones; redirect_count wraps.

## Timing
- start high at edge N -> init_ctrl high cycle N+1 -> RUN at edge N+2.
- Redirect: controls asserted same cycle as decode inputs (zero latency); squash asserted that cycle plus FLUSH_CYCLES following non-stalled cycles.
- Halt: done_ctrl asserted same cycle as dec_is_halt and held.
- reset_n low mid-operation: immediate return to IDLE outputs, counters 0, regardless of clock.

## Test plan
- Reset then start pulse: init_ctrl=1 for one cycle, then RUN, stall=0, busy=1, counters 0.
- Taken branch in RUN, FLUSH_CYCLES=1: branch_ctrl=1 and squash=1 that cycle, squash=1 next cycle, then RUN; redirect_count=1. Not-taken branch: no controls, count unchanged.
- Jump and taken branch same cycle: only branch_ctrl=1; jump during FLUSH ignored; redirect_count=1.
- mem_wait held 3 cycles in RUN then hazard 1 cycle: stall=1 for 4 cycles, stall_count=4, no redirects issued even with dec_is_jump asserted; mem_wait in FLUSH extends squash by 3 cycles.
- Halt: done_ctrl=1, stall=1 held in HALT; start -> INIT, init_ctrl pulse, counters 0. Force stall_count to all-ones-1, 2 stalls -> saturates.
- reset_n low during FLUSH: outputs immediately 0 except stall=1, state IDLE, busy=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Control FSM for the 8-bit fetch unit: start-up, stalls, post-redirect squash and halt,
// with stall-cycle and redirect performance counters.
module fetch_sequencer #(
   parameter int FLUSH_CYCLES = 1,
   parameter int STALL_CNT_W  = 16
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic                   dec_valid,
   input  logic                   dec_is_branch,
   input  logic                   branch_cond,
   input  logic                   dec_is_jump,
   input  logic                   dec_is_halt,
   input  logic                   hazard,
   input  logic                   mem_wait,
   output logic                   init_ctrl,
   output logic                   branch_ctrl,
   output logic                   jump_ctrl,
   output logic                   stall,
   output logic                   done_ctrl,
   output logic                   squash,
   output logic                   busy,
   output logic [STALL_CNT_W-1:0] stall_count,
   output logic [7:0]             redirect_count
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INIT  = 3'd1,
      RUN   = 3'd2,
      FLUSH = 3'd3,
      HALT  = 3'd4
   } state_t;

   localparam logic [3:0]             FLUSH_INIT = 4'(FLUSH_CYCLES);
   localparam logic [STALL_CNT_W-1:0] STALL_MAX  = {STALL_CNT_W{1'b1}};
   localparam logic [STALL_CNT_W-1:0] STALL_ONE  = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

   state_t                   state_r;
   state_t                   state_nxt_s;
   logic [3:0]               flush_cnt_r;
   logic [3:0]               flush_cnt_nxt_s;
   logic                     stall_inc_s;
   logic                     redir_inc_s;
   logic                     cnt_clr_s;
   logic [STALL_CNT_W-1:0]   stall_cnt_r;
   logic [7:0]               redirect_cnt_r;

   // Next-state and Mealy control decode from registered state and current inputs
   always_comb begin
      state_nxt_s     = state_r;
      flush_cnt_nxt_s = flush_cnt_r;
      init_ctrl       = 1'b0;
      branch_ctrl     = 1'b0;
      jump_ctrl       = 1'b0;
      stall           = 1'b0;
      done_ctrl       = 1'b0;
      squash          = 1'b0;
      stall_inc_s     = 1'b0;
      redir_inc_s     = 1'b0;
      cnt_clr_s       = 1'b0;
      case (state_r)
         IDLE: begin
            stall = 1'b1;
            if (start) begin
               state_nxt_s = INIT;
               cnt_clr_s   = 1'b1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         INIT: begin
            init_ctrl   = 1'b1;
            state_nxt_s = RUN;
         end
         RUN: begin
            if (!dec_valid) begin
               state_nxt_s = RUN;
            end else if (dec_is_halt) begin
               done_ctrl   = 1'b1;
               stall       = 1'b1;
               state_nxt_s = HALT;
            end else if (hazard || mem_wait) begin
               stall       = 1'b1;
               stall_inc_s = 1'b1;
            end else if ((dec_is_branch && branch_cond) || dec_is_jump) begin
               // Branch outranks jump, matching the fetch unit's own priority
               branch_ctrl = dec_is_branch && branch_cond;
               jump_ctrl   = !(dec_is_branch && branch_cond);
               squash      = 1'b1;
               redir_inc_s = 1'b1;
               if (FLUSH_INIT != 4'd0) begin
                  state_nxt_s     = FLUSH;
                  flush_cnt_nxt_s = FLUSH_INIT;
               end else begin
                  state_nxt_s = RUN;
               end
            end else begin
               state_nxt_s = RUN;
            end
         end
         FLUSH: begin
            squash = 1'b1;
            if (mem_wait) begin
               stall       = 1'b1;
               stall_inc_s = 1'b1;
            end else begin
               flush_cnt_nxt_s = flush_cnt_r - 4'd1;
               if (flush_cnt_r == 4'd1) begin
                  state_nxt_s = RUN;
               end else begin
                  state_nxt_s = FLUSH;
               end
            end
         end
         HALT: begin
            done_ctrl = 1'b1;
            stall     = 1'b1;
            if (start) begin
               state_nxt_s = INIT;
               cnt_clr_s   = 1'b1;
            end else begin
               state_nxt_s = HALT;
            end
         end
         default: begin
            stall       = 1'b1;
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State and squash-bubble counter registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= IDLE;
         flush_cnt_r <= 4'd0;
      end else begin
         state_r     <= state_nxt_s;
         flush_cnt_r <= flush_cnt_nxt_s;
      end
   end

   // Performance counters: stall cycles saturate, redirects wrap
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt_r    <= {STALL_CNT_W{1'b0}};
         redirect_cnt_r <= 8'd0;
      end else if (cnt_clr_s) begin
         stall_cnt_r    <= {STALL_CNT_W{1'b0}};
         redirect_cnt_r <= 8'd0;
      end else begin
         if (stall_inc_s && (stall_cnt_r != STALL_MAX)) begin
            stall_cnt_r <= stall_cnt_r + STALL_ONE;
         end
         if (redir_inc_s) begin
            redirect_cnt_r <= redirect_cnt_r + 8'd1;
         end
      end
   end

   assign busy           = (state_r == INIT) || (state_r == RUN) || (state_r == FLUSH);
   assign stall_count    = stall_cnt_r;
   assign redirect_count = redirect_cnt_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer (FLUSH_CYCLES=1, 4-bit stall counter
// so saturation is reachable quickly).
module tb_fetch_sequencer;

   localparam int SCW = 4;

   // Input vector bit positions: {start, valid, branch, cond, jump, halt, hazard, mem_wait}
   localparam logic [7:0] ST = 8'h80;
   localparam logic [7:0] V  = 8'h40;
   localparam logic [7:0] BR = 8'h20;
   localparam logic [7:0] CD = 8'h10;
   localparam logic [7:0] JP = 8'h08;
   localparam logic [7:0] HL = 8'h04;
   localparam logic [7:0] HZ = 8'h02;
   localparam logic [7:0] MW = 8'h01;

   // Control vector: {init, branch, jump, stall, done, squash, busy}
   localparam logic [6:0] C_IDLE  = 7'b0001000;
   localparam logic [6:0] C_INIT  = 7'b1000001;
   localparam logic [6:0] C_RUN   = 7'b0000001;
   localparam logic [6:0] C_BR    = 7'b0100011;
   localparam logic [6:0] C_JP    = 7'b0010011;
   localparam logic [6:0] C_FLUSH = 7'b0000011;
   localparam logic [6:0] C_FSTL  = 7'b0001011;
   localparam logic [6:0] C_STALL = 7'b0001001;
   localparam logic [6:0] C_HALTI = 7'b0001101;
   localparam logic [6:0] C_HALT  = 7'b0001100;

   logic clock = 1'b0;
   logic reset_n;
   logic start, dec_valid, dec_is_branch, branch_cond, dec_is_jump, dec_is_halt, hazard, mem_wait;
   logic init_ctrl, branch_ctrl, jump_ctrl, stall, done_ctrl, squash, busy;
   logic [SCW-1:0] stall_count;
   logic [7:0]     redirect_count;
   logic [6:0]     ctl;

   int checks = 0;
   int errors = 0;

   fetch_sequencer #(.FLUSH_CYCLES(1), .STALL_CNT_W(SCW)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .dec_valid(dec_valid),
      .dec_is_branch(dec_is_branch), .branch_cond(branch_cond), .dec_is_jump(dec_is_jump),
      .dec_is_halt(dec_is_halt), .hazard(hazard), .mem_wait(mem_wait),
      .init_ctrl(init_ctrl), .branch_ctrl(branch_ctrl), .jump_ctrl(jump_ctrl), .stall(stall),
      .done_ctrl(done_ctrl), .squash(squash), .busy(busy),
      .stall_count(stall_count), .redirect_count(redirect_count)
   );

   always #5 clock = ~clock;

   assign ctl = {init_ctrl, branch_ctrl, jump_ctrl, stall, done_ctrl, squash, busy};

   task automatic drive(input logic [7:0] v);
      {start, dec_valid, dec_is_branch, branch_cond, dec_is_jump, dec_is_halt, hazard, mem_wait} = v;
      #1;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      drive(8'h00);
      chk("reset_ctl", 32'(ctl), 32'(C_IDLE));
      chk("reset_stall_cnt", 32'(stall_count), 32'd0);
      chk("reset_redir_cnt", 32'(redirect_count), 32'd0);
      #10 reset_n = 1'b1;
      tick();
      drive(8'h00);
      chk("idle_ctl", 32'(ctl), 32'(C_IDLE));

      // Start pulse: INIT for one cycle, then RUN
      drive(ST);
      chk("idle_start_ctl", 32'(ctl), 32'(C_IDLE));
      tick();
      drive(8'h00);
      chk("init_ctl", 32'(ctl), 32'(C_INIT));
      chk("init_stall_cnt", 32'(stall_count), 32'd0);
      tick();
      chk("run_ctl", 32'(ctl), 32'(C_RUN));
      tick();
      chk("run_ctl2", 32'(ctl), 32'(C_RUN));

      // Taken branch, jump during FLUSH ignored, then not-taken branch
      drive(V | BR | CD);
      chk("br_taken_ctl", 32'(ctl), 32'(C_BR));
      tick();
      drive(V | JP);
      chk("flush_jump_ignored", 32'(ctl), 32'(C_FLUSH));
      chk("redir_cnt_1", 32'(redirect_count), 32'd1);
      tick();
      drive(V | BR);
      chk("br_not_taken_ctl", 32'(ctl), 32'(C_RUN));
      tick();
      chk("redir_cnt_still_1", 32'(redirect_count), 32'd1);

      // Lone jump, then jump together with taken branch: branch wins
      drive(V | JP);
      chk("jump_ctl", 32'(ctl), 32'(C_JP));
      tick();
      drive(8'h00);
      tick();
      drive(V | BR | CD | JP);
      chk("br_jp_both_ctl", 32'(ctl), 32'(C_BR));
      tick();
      drive(8'h00);
      chk("both_flush_ctl", 32'(ctl), 32'(C_FLUSH));
      tick();
      chk("both_back_run", 32'(ctl), 32'(C_RUN));
      chk("redir_cnt_3", 32'(redirect_count), 32'd3);

      // mem_wait x3 then hazard x1 with a jump pending: stalls only
      drive(V | JP | MW);
      for (int i = 0; i < 3; i++) begin
         chk("memwait_stall_ctl", 32'(ctl), 32'(C_STALL));
         tick();
      end
      drive(V | JP | HZ);
      chk("hazard_stall_ctl", 32'(ctl), 32'(C_STALL));
      tick();
      drive(8'h00);
      chk("stall_cnt_4", 32'(stall_count), 32'd4);
      chk("redir_cnt_no_change", 32'(redirect_count), 32'd3);

      // Hazard without a valid instruction neither stalls nor counts
      drive(HZ);
      chk("hazard_novalid_ctl", 32'(ctl), 32'(C_RUN));
      tick();
      chk("stall_cnt_still_4", 32'(stall_count), 32'd4);

      // mem_wait in FLUSH stretches squash by 3 cycles
      drive(V | BR | CD);
      tick();
      drive(MW | V | JP);
      for (int i = 0; i < 3; i++) begin
         chk("flush_memwait_ctl", 32'(ctl), 32'(C_FSTL));
         tick();
      end
      drive(HZ);
      chk("flush_hazard_ignored", 32'(ctl), 32'(C_FLUSH));
      tick();
      drive(8'h00);
      chk("flush_exit_run", 32'(ctl), 32'(C_RUN));
      chk("stall_cnt_7", 32'(stall_count), 32'd7);
      chk("redir_cnt_4", 32'(redirect_count), 32'd4);

      // Saturation of the stall counter
      drive(V | MW);
      for (int i = 0; i < 7; i++) tick();
      chk("stall_cnt_max_m1", 32'(stall_count), 32'd14);
      tick();
      tick();
      chk("stall_cnt_sat", 32'(stall_count), 32'd15);

      // Halt outranks hazard; HALT is sticky; start re-inits and clears counters
      drive(V | HL | HZ);
      chk("halt_issue_ctl", 32'(ctl), 32'(C_HALTI));
      tick();
      drive(V | BR | CD);
      chk("halt_ctl", 32'(ctl), 32'(C_HALT));
      tick();
      chk("halt_sticky_ctl", 32'(ctl), 32'(C_HALT));
      chk("halt_stall_cnt", 32'(stall_count), 32'd15);
      drive(ST);
      tick();
      drive(8'h00);
      chk("reinit_ctl", 32'(ctl), 32'(C_INIT));
      chk("reinit_stall_cnt", 32'(stall_count), 32'd0);
      chk("reinit_redir_cnt", 32'(redirect_count), 32'd0);
      tick();

      // start ignored while running
      drive(ST);
      chk("run_start_ctl", 32'(ctl), 32'(C_RUN));
      tick();
      drive(8'h00);
      chk("run_start_ignored", 32'(ctl), 32'(C_RUN));

      // Redirect counter wraps 255 -> 0
      for (int i = 0; i < 255; i++) begin
         drive(V | BR | CD);
         tick();
         drive(8'h00);
         tick();
      end
      chk("redir_cnt_255", 32'(redirect_count), 32'd255);
      drive(V | JP);
      tick();
      drive(8'h00);
      tick();
      chk("redir_cnt_wrap", 32'(redirect_count), 32'd0);

      // Asynchronous reset while in FLUSH
      drive(V | BR | CD);
      tick();
      drive(8'h00);
      chk("pre_reset_flush", 32'(ctl), 32'(C_FLUSH));
      #2 reset_n = 1'b0;
      #1;
      chk("async_reset_ctl", 32'(ctl), 32'(C_IDLE));
      chk("async_reset_redir", 32'(redirect_count), 32'd0);
      tick();
      chk("reset_held_ctl", 32'(ctl), 32'(C_IDLE));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
